// File: rtl/fifo_pkg.sv
// Shared FIFO constants and types used by the FIFO and its write arbiter.
package fifo_pkg;
   localparam int FIFO_DEPTH = 16;
   localparam int DATA_WIDTH = 8;
   localparam int PTR_SIZE   = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      THROTTLE,
      ERROR
   } arb_state_t;

   typedef logic [PTR_SIZE:0] credit_t;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of elig searching upward from ptr+1.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         elig,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         onehot,
   output logic                 valid
);
   localparam int IW = $clog2(N);

   logic [IW-1:0] idx;

   always_comb begin
      onehot = '0;
      idx    = '0;
      for (int i = 1; i <= N; i++) begin
         idx = IW'((int'(ptr) + i) % N);
         if (onehot == '0 && elig[idx])
            onehot[idx] = 1'b1;
      end
   end

   assign valid = |elig;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for a shared FIFO with local credit tracking
// and a sticky overflow error that halts grants until cleared.
module fifo_wr_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int FIFO_DEPTH   = 16,
   parameter int CREDIT_LIMIT = 15
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            en,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   input  logic                            rd_n,
   input  logic                            over_flow,
   input  logic                            clr_err,
   output logic                            wr_n,
   output logic [DATA_WIDTH-1:0]           data_in,
   output logic [NUM_REQ-1:0]              gnt,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id,
   output logic [$clog2(FIFO_DEPTH):0]     occupancy,
   output logic                            err
);
   import fifo_pkg::*;

   localparam int IW = $clog2(NUM_REQ);
   localparam int OW = $clog2(FIFO_DEPTH) + 1;

   arb_state_t         state;
   arb_state_t         state_nxt;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] pick_oh;
   logic               pick_vld;
   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      win;
   logic [OW-1:0]      occ_nxt;
   logic               drain;
   logic               room;
   logic               issue;

   // A requester seeing gnt this cycle still shows its stale req/data.
   assign elig  = req & ~gnt;
   assign drain = !rd_n && (occupancy != '0);
   // A drain on this edge frees the slot the new write will take.
   assign room  = (occupancy < OW'(CREDIT_LIMIT)) || drain;
   assign issue = en && (state != ERROR) && !over_flow
                  && pick_vld && room;

   rr_pick #(
      .N(NUM_REQ)
   ) u_pick (
      .elig   (elig),
      .ptr    (rr_ptr),
      .onehot (pick_oh),
      .valid  (pick_vld)
   );

   always_comb begin
      win = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (pick_oh[i])
            win = IW'(i);
   end

   assign occ_nxt = occupancy + OW'(issue) - OW'(drain);

   always_comb begin
      state_nxt = state;
      if (over_flow)
         state_nxt = ERROR;
      else if (state == ERROR) begin
         if (clr_err)
            state_nxt = IDLE;
      end else if (!en)
         state_nxt = IDLE;
      else if (issue)
         state_nxt = ACTIVE;
      else if (pick_vld)
         state_nxt = THROTTLE;
      else
         state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_n      <= 1'b1;
         data_in   <= '0;
         gnt       <= '0;
         grant_id  <= '0;
         occupancy <= '0;
         err       <= 1'b0;
         rr_ptr    <= IW'(NUM_REQ - 1);
      end else begin
         occupancy <= occ_nxt;
         if (over_flow)
            err <= 1'b1;
         else if (clr_err)
            err <= 1'b0;
         if (issue) begin
            wr_n     <= 1'b0;
            gnt      <= pick_oh;
            data_in  <= req_data[win*DATA_WIDTH +: DATA_WIDTH];
            grant_id <= win;
            rr_ptr   <= win;
         end else begin
            wr_n <= 1'b1;
            gnt  <= '0;
         end
      end
   end
endmodule
